// File: rtl/ahb_lite_mem_subsys_pkg.sv
// ahb_lite_mem_subsys_pkg: shared AHB-Lite types and the byte-lane mask helper.
package ahb_lite_mem_subsys_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, BUSY = 2'b01, NONSEQ = 2'b10, SEQ = 2'b11} htrans_t;
  typedef enum logic [2:0] {SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD, SZ_4W, SZ_8W, SZ_16W, SZ_32W} hsize_t;
  typedef enum logic {OKAY = 1'b0, ERROR = 1'b1} hresp_t;
  typedef enum logic [1:0] {S_OKAY, S_WAIT, S_ERR1, S_ERR2} resp_state_t;

  // Sizes above a doubleword are rejected before this mask is used.
  function automatic logic [7:0] lane_mask(input logic [2:0] size, input logic [2:0] lo);
    logic [8:0] m;
    m = (9'd1 << (4'd1 << size)) - 9'd1;
    return m[7:0] << lo;
  endfunction
endpackage

// File: rtl/ahb_lane_mem.sv
// ahb_lane_mem: one synchronous memory bank with per-byte write enables and a registered read port.
module ahb_lane_mem #(
  parameter int DATA_W = 32,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_re,
  input  logic [AW-1:0]     i_raddr,
  input  logic [DATA_W/8-1:0] i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  logic [DATA_W-1:0] r_mem [2**AW];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int i = 0; i < DATA_W/8; i++)
      if (i_we[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
  end

  // Read sees the pre-write contents; the top level merges same-edge writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ahb_lite_mem_subsys.sv
// ahb_lite_mem_subsys: AHB-Lite slave fronting NUM_SLAVES memory banks with decode, wait states and ERROR responses.
module ahb_lite_mem_subsys import ahb_lite_mem_subsys_pkg::*; #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int NUM_SLAVES  = 4,
  parameter int MEM_AW      = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic              HSEL,
  input  logic [ADDR_W-1:0] HADDR,
  input  logic [1:0]        HTRANS,
  input  logic              HWRITE,
  input  logic [2:0]        HSIZE,
  input  logic [2:0]        HBURST,
  input  logic [DATA_W-1:0] HWDATA,
  output logic [DATA_W-1:0] HRDATA,
  output logic              HREADY,
  output logic              HRESP
);
  localparam int NB = DATA_W/8;
  localparam int LB = $clog2(NB);
  localparam int BW = $clog2(NUM_SLAVES);

  resp_state_t r_state, w_state_nxt;
  logic [3:0] r_cnt, w_cnt_nxt;
  logic r_dp_wr;
  logic [BW-1:0] r_dp_bank, r_rd_bank, w_bank;
  logic [MEM_AW-1:0] r_dp_word, w_word;
  logic [NB-1:0] r_dp_mask, r_fwd_mask, w_mask;
  logic [DATA_W-1:0] r_fwd_data, w_rsel;
  logic [DATA_W-1:0] w_rdata [NUM_SLAVES];
  logic [7:0] w_lo, w_mask8;
  logic w_acc, w_err, w_rd, w_commit, w_fwd, w_unused;

  assign HREADY = r_state == S_OKAY || r_state == S_ERR2;
  assign HRESP = (r_state == S_ERR1 || r_state == S_ERR2) ? ERROR : OKAY;
  assign w_acc = HREADY && HSEL && (HTRANS == NONSEQ || HTRANS == SEQ);
  assign w_bank = HADDR[MEM_AW+LB +: BW];
  assign w_word = HADDR[LB +: MEM_AW];
  assign w_lo = 8'(HADDR[LB-1:0]);
  assign w_mask8 = lane_mask(HSIZE, w_lo[2:0]);
  assign w_mask = w_mask8[NB-1:0];
  assign w_err = |(HADDR >> (MEM_AW+LB+BW)) || HSIZE > 3'(LB) || |(w_lo & ~(8'hFF << HSIZE));
  assign w_rd = w_acc && !w_err && !HWRITE;
  assign w_commit = r_dp_wr && HREADY;
  assign w_fwd = w_rd && w_commit && w_bank == r_dp_bank && w_word == r_dp_word;
  assign w_unused = ^{HBURST, w_mask8};

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state <= S_OKAY;
      r_cnt <= '0;
      r_dp_wr <= 1'b0;
      r_dp_bank <= '0;
      r_dp_word <= '0;
      r_dp_mask <= '0;
      r_rd_bank <= '0;
      r_fwd_mask <= '0;
      r_fwd_data <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt <= w_cnt_nxt;
      if (HREADY) begin
        r_dp_wr <= w_acc && !w_err && HWRITE;
        r_dp_bank <= w_bank;
        r_dp_word <= w_word;
        r_dp_mask <= w_mask;
      end
      if (w_rd) begin
        r_rd_bank <= w_bank;
        r_fwd_mask <= w_fwd ? r_dp_mask : '0;
        r_fwd_data <= HWDATA;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_WAIT: begin
        w_cnt_nxt = r_cnt - 4'd1;
        w_state_nxt = r_cnt == 4'd1 ? S_OKAY : S_WAIT;
      end
      S_ERR1: w_state_nxt = S_ERR2;
      default: begin
        w_state_nxt = !w_acc ? S_OKAY : w_err ? S_ERR1 : WAIT_CYCLES > 0 ? S_WAIT : S_OKAY;
        w_cnt_nxt = (w_acc && !w_err) ? 4'(WAIT_CYCLES) : 4'd0;
      end
    endcase
  end

  genvar b;
  for (b = 0; b < NUM_SLAVES; b++) begin : g_bank
    ahb_lane_mem #(.DATA_W(DATA_W), .AW(MEM_AW)) u_mem (
      .clk(HCLK),
      .rst_n(HRESETn),
      .i_re(w_rd && w_bank == BW'(b)),
      .i_raddr(w_word),
      .i_we({NB{w_commit && r_dp_bank == BW'(b)}} & r_dp_mask),
      .i_waddr(r_dp_word),
      .i_wdata(HWDATA),
      .o_rdata(w_rdata[b])
    );
  end

  always_comb begin
    w_rsel = w_rdata[r_rd_bank];
    for (int i = 0; i < NB; i++)
      if (r_fwd_mask[i]) w_rsel[8*i +: 8] = r_fwd_data[8*i +: 8];
  end

  assign HRDATA = w_rsel;
endmodule

// File: tb/tb_ahb_lite_mem_subsys.sv
// tb_ahb_lite_mem_subsys: directed vector bench over three instances with 0, 3 and 2 wait states.
module tb_ahb_lite_mem_subsys;
  logic HCLK = 1'b0;
  logic HRESETn, HSEL, HWRITE;
  logic [31:0] HADDR, HWDATA;
  logic [1:0] HTRANS;
  logic [2:0] HSIZE, HBURST;
  logic [31:0] rd [3];
  logic rdy [3];
  logic rsp [3];
  int sel;
  logic [31:0] hrdata;
  logic hready, hresp;
  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ahb_lite_mem_subsys #(
      .DATA_W(32), .ADDR_W(32), .NUM_SLAVES(4), .MEM_AW(8),
      .WAIT_CYCLES(g == 0 ? 0 : g == 1 ? 3 : 2)
    ) u_dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HWDATA(HWDATA),
      .HRDATA(rd[g]), .HREADY(rdy[g]), .HRESP(rsp[g])
    );
  end

  assign hrdata = rd[sel];
  assign hready = rdy[sel];
  assign hresp = rsp[sel];

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  sz;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    int          exp_waits;
    logic        exp_err;
  } vec_t;

  vec_t tab [19];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic idle(input int n);
    HTRANS = 2'b00;
    HSEL = 1'b0;
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Starts in a cycle where the selected DUT has HREADY=1; returns in the last data-phase cycle.
  task automatic xfer(input logic wr, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd,
                      output logic [31:0] rdv, output int waits, output logic r1, output logic rend);
    HSEL = 1'b1; HADDR = a; HTRANS = 2'b10; HWRITE = wr; HSIZE = sz;
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HSEL = 1'b0; HWDATA = wd;
    r1 = hresp;
    waits = 0;
    while (!hready && waits < 20) begin
      waits++;
      @(posedge HCLK); #1;
    end
    rdv = hrdata;
    rend = hresp;
  endtask

  initial begin
    logic [31:0] rdv;
    int waits, n;
    logic r1, rend;
    tab = '{
      '{1'b1, 32'h404,  3'd2, 32'hDEADBEEF, 32'h0,        0, 1'b0},
      '{1'b0, 32'h404,  3'd2, 32'h0,        32'hDEADBEEF, 0, 1'b0},
      '{1'b1, 32'h000,  3'd2, 32'h11223344, 32'h0,        0, 1'b0},
      '{1'b1, 32'h001,  3'd0, 32'h00005500, 32'h0,        0, 1'b0},
      '{1'b0, 32'h000,  3'd2, 32'h0,        32'h11225544, 0, 1'b0},
      '{1'b1, 32'h002,  3'd1, 32'hBEEF0000, 32'h0,        0, 1'b0},
      '{1'b0, 32'h000,  3'd2, 32'h0,        32'hBEEF5544, 0, 1'b0},
      '{1'b0, 32'h1000, 3'd2, 32'h0,        32'h0,        1, 1'b1},
      '{1'b1, 32'h1000, 3'd2, 32'hFFFFFFFF, 32'h0,        1, 1'b1},
      '{1'b0, 32'h000,  3'd2, 32'h0,        32'hBEEF5544, 0, 1'b0},
      '{1'b0, 32'h404,  3'd2, 32'h0,        32'hDEADBEEF, 0, 1'b0},
      '{1'b0, 32'h001,  3'd1, 32'h0,        32'h0,        1, 1'b1},
      '{1'b0, 32'h000,  3'd3, 32'h0,        32'h0,        1, 1'b1},
      '{1'b1, 32'h003,  3'd0, 32'h77000000, 32'h0,        0, 1'b0},
      '{1'b0, 32'h000,  3'd2, 32'h0,        32'h77EF5544, 0, 1'b0},
      '{1'b1, 32'hC08,  3'd2, 32'hCAFEF00D, 32'h0,        0, 1'b0},
      '{1'b0, 32'hC08,  3'd2, 32'h0,        32'hCAFEF00D, 0, 1'b0},
      '{1'b0, 32'h406,  3'd1, 32'h0,        32'hDEADBEEF, 0, 1'b0},
      '{1'b1, 32'h00A,  3'd2, 32'h12345678, 32'h0,        1, 1'b1}
    };
    sel = 0;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = '0; HTRANS = 2'b00; HWRITE = 1'b0;
    HSIZE = 3'd2; HBURST = 3'd0; HWDATA = '0;
    repeat (3) @(posedge HCLK);
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_hready%0d", i), 32'(rdy[i]), 32'd1);
      chk($sformatf("rst_hresp%0d", i), 32'(rsp[i]), 32'd0);
      chk($sformatf("rst_hrdata%0d", i), rd[i], 32'h0);
    end
    HRESETn = 1'b1;
    @(posedge HCLK); #1;

    for (int i = 0; i < 19; i++) begin
      xfer(tab[i].wr, tab[i].addr, tab[i].sz, tab[i].wd, rdv, waits, r1, rend);
      chk($sformatf("vec%0d_waits", i), 32'(waits), 32'(tab[i].exp_waits));
      chk($sformatf("vec%0d_resp1", i), 32'(r1), 32'(tab[i].exp_err));
      chk($sformatf("vec%0d_resp2", i), 32'(rend), 32'(tab[i].exp_err));
      if (!tab[i].wr && !tab[i].exp_err) chk($sformatf("vec%0d_rdata", i), rdv, tab[i].exp_rd);
    end

    // Byte write to 0x807 with the read of 0x804 in its data phase.
    xfer(1'b1, 32'h804, 3'd2, 32'h11223344, rdv, waits, r1, rend);
    chk("fwd_pre_waits", 32'(waits), 32'd0);
    HSEL = 1'b1; HADDR = 32'h807; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd0;
    @(posedge HCLK); #1;
    HWDATA = 32'hAA000000; HADDR = 32'h804; HWRITE = 1'b0; HSIZE = 3'd2;
    chk("fwd_wr_hready", 32'(hready), 32'd1);
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HSEL = 1'b0;
    chk("fwd_rd_hready", 32'(hready), 32'd1);
    chk("fwd_rd_data", hrdata, 32'hAA223344);
    xfer(1'b0, 32'h804, 3'd2, 32'h0, rdv, waits, r1, rend);
    chk("fwd_commit_data", rdv, 32'hAA223344);

    sel = 1;
    idle(8);
    for (int k = 0; k < 4; k++) begin
      xfer(1'b1, 32'hC00 + 32'(4*k), 3'd2, 32'h3C000000 + 32'(k), rdv, waits, r1, rend);
      chk($sformatf("w3_wr%0d_waits", k), 32'(waits), 32'd3);
    end
    HSEL = 1'b1; HADDR = 32'hC00; HTRANS = 2'b10; HWRITE = 1'b0; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        HADDR = 32'hC04 + 32'(4*k); HTRANS = 2'b11;
      end else begin
        HTRANS = 2'b00; HSEL = 1'b0;
      end
      n = 0;
      while (!hready && n < 20) begin
        n++;
        @(posedge HCLK); #1;
      end
      chk($sformatf("seq%0d_waits", k), 32'(n), 32'd3);
      chk($sformatf("seq%0d_data", k), hrdata, 32'h3C000000 + 32'(k));
      @(posedge HCLK); #1;
    end

    sel = 2;
    idle(8);
    xfer(1'b1, 32'h008, 3'd2, 32'h0BADF00D, rdv, waits, r1, rend);
    chk("w2_wr_waits", 32'(waits), 32'd2);
    xfer(1'b0, 32'h008, 3'd2, 32'h0, rdv, waits, r1, rend);
    chk("w2_rd_waits", 32'(waits), 32'd2);
    chk("w2_rd_data", rdv, 32'h0BADF00D);
    HSEL = 1'b1; HADDR = 32'h008; HTRANS = 2'b10; HWRITE = 1'b1; HSIZE = 3'd2;
    @(posedge HCLK); #1;
    HTRANS = 2'b00; HSEL = 1'b0; HWDATA = 32'hFFFFFFFF;
    chk("rst_mid_hready_low", 32'(hready), 32'd0);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_mid_hready", 32'(hready), 32'd1);
    chk("rst_mid_hresp", 32'(hresp), 32'd0);
    chk("rst_mid_hrdata", hrdata, 32'h0);
    repeat (2) @(posedge HCLK);
    #1 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer(1'b0, 32'h008, 3'd2, 32'h0, rdv, waits, r1, rend);
    chk("rst_keep_waits", 32'(waits), 32'd2);
    chk("rst_keep_data", rdv, 32'h0BADF00D);

    idle(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
